timer_seq_ctrl: RTL

TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

---
 rtl/timer_ctrl_pkg.sv | 9 +
 rtl/timer_seq_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state encodings for the timer sequencing controller
package timer_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/timer_seq_ctrl.sv
// rtl/timer_seq_ctrl.sv - start/stop/one-shot sequencer driving an external basic timer
module timer_seq_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int timer_width      = 16,
    parameter int rep_width        = 8,
    parameter int simulation_delay = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sw_start,
    input  logic                   sw_stop,
    input  logic                   cfg_oneshot,
    input  logic [rep_width-1:0]   cfg_rep,
    input  logic                   cfg_down,
    input  logic [timer_width-1:0] cfg_prescale,
    input  logic [timer_width-1:0] cfg_autoload,
    input  logic [timer_width-1:0] cfg_cnt_init,
    input  logic                   cfg_update,
    output logic                   timer_started,
    output logic                   timer_down,
    output logic [timer_width-1:0] prescale,
    output logic [timer_width-1:0] autoload,
    output logic                   timer_cnt_to_set,
    output logic [timer_width-1:0] timer_cnt_set_v,
    input  logic                   timer_expired,
    input  logic                   itr_en,
    input  logic                   itr_clr,
    output logic                   itr_pending,
    output logic                   itr_req,
    output logic                   busy,
    output logic                   done,
    output logic [rep_width-1:0]   rep_left
);

    // simulation_delay is kept for interface compatibility; it only feeds this range hook
    if (timer_width < 8 || timer_width > 32 || simulation_delay < 0) begin : g_param_range
    end

    logic [1:0]             state;
    logic                   oneshot_q;
    logic [timer_width-1:0] cnt_init_q;
    logic                   counted;

    // A stop in the same cycle wins over the expiry, so that expiry is dropped entirely
    assign counted = (state == ST_RUN) && timer_expired && !sw_stop;

    assign busy             = (state != ST_IDLE);
    assign timer_started    = (state == ST_RUN);
    assign timer_cnt_to_set = (state == ST_LOAD);
    assign done             = (state == ST_DONE);
    assign timer_cnt_set_v  = cnt_init_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            oneshot_q   <= 1'b0;
            cnt_init_q  <= '0;
            timer_down  <= 1'b0;
            prescale    <= '0;
            autoload    <= '0;
            rep_left    <= '0;
            itr_pending <= 1'b0;
            itr_req     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sw_start && !sw_stop) begin
                        timer_down <= cfg_down;
                        prescale   <= cfg_prescale;
                        autoload   <= cfg_autoload;
                        cnt_init_q <= cfg_cnt_init;
                        oneshot_q  <= cfg_oneshot;
                        rep_left   <= cfg_rep;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_RUN;
                ST_RUN: begin
                    if (cfg_update) begin
                        prescale <= cfg_prescale;
                        autoload <= cfg_autoload;
                    end
                    if (sw_stop) begin
                        state <= ST_IDLE;
                    end else if (counted && oneshot_q) begin
                        if (rep_left != '0) begin
                            rep_left <= rep_left - rep_width'(1);
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (counted) begin
                itr_pending <= 1'b1;
            end else if (itr_clr) begin
                itr_pending <= 1'b0;
            end
            itr_req <= counted && itr_en;
        end
    end

endmodule
